// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage CPU pipeline registers.
// The control struct is reused by the ID/EX, EX/MEM and MEM/WB stages.
package cpu_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 4;

   // MEM/WB control bundle carried down the pipe; a zero value is a bubble.
   typedef struct packed {
      logic muxWb;      // 0 = memory data, 1 = ALU result
      logic memRead;
      logic memWrite;
      logic regWrite;
      logic regWrite0;
   } ex_mem_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterized flop with asynchronous active-high clear.
module pipe_reg #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: stores execute results, register indices and
// MEM/WB controls for one cycle. Reset yields a bubble.
module ex_mem_pipe_reg #(
   parameter int DATA_W     = cpu_pkg::DATA_W,
   parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     alu_in,
   input  logic [DATA_W-1:0]     rd1_in,
   input  logic [DATA_W-1:0]     r0_in,
   input  logic [REG_ADDR_W-1:0] rr1_in,
   input  logic [REG_ADDR_W-1:0] waddr_in,
   input  logic                  mux_wb_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  reg_write_in,
   input  logic                  reg_write0_in,
   output logic [DATA_W-1:0]     alu_out,
   output logic [DATA_W-1:0]     rd1_out,
   output logic [DATA_W-1:0]     r0_out,
   output logic [REG_ADDR_W-1:0] rr1_out,
   output logic [REG_ADDR_W-1:0] waddr_out,
   output logic                  mux_wb_out,
   output logic                  mem_read_out,
   output logic                  mem_write_out,
   output logic                  reg_write_out,
   output logic                  reg_write0_out
);
   import cpu_pkg::*;

   localparam int CTRL_W = $bits(ex_mem_ctrl_t);
   localparam int BUS_W  = 3*DATA_W + 2*REG_ADDR_W + CTRL_W;

   ex_mem_ctrl_t     ctrlIn, ctrlOut;
   logic [BUS_W-1:0] busIn, busOut;

   assign ctrlIn = '{muxWb:     mux_wb_in,
                     memRead:   mem_read_in,
                     memWrite:  mem_write_in,
                     regWrite:  reg_write_in,
                     regWrite0: reg_write0_in};

   // One flop bank over the whole bundle keeps every field on the same edge.
   assign busIn = {alu_in, rd1_in, r0_in, rr1_in, waddr_in, ctrlIn};

   pipe_reg #(.W(BUS_W)) uStage (
      .clock (clock),
      .reset (reset),
      .d     (busIn),
      .q     (busOut)
   );

   assign {alu_out, rd1_out, r0_out, rr1_out, waddr_out, ctrlOut} = busOut;

   assign mux_wb_out     = ctrlOut.muxWb;
   assign mem_read_out   = ctrlOut.memRead;
   assign mem_write_out  = ctrlOut.memWrite;
   assign reg_write_out  = ctrlOut.regWrite;
   assign reg_write0_out = ctrlOut.regWrite0;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed reset/latency sequences, a vector
// table of boundary patterns, and a randomized stream against a latch model.
module tb_ex_mem_pipe_reg;

   typedef struct packed {
      logic [15:0] alu;
      logic [15:0] rd1;
      logic [15:0] r0;
      logic [3:0]  rr1;
      logic [3:0]  waddr;
      logic [4:0]  ctrl;   // {mux_wb, mem_read, mem_write, reg_write, reg_write0}
   } fields_t;

   typedef struct {
      fields_t stim;
      fields_t exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] alu_in, rd1_in, r0_in;
   logic [3:0]  rr1_in, waddr_in;
   logic        mux_wb_in, mem_read_in, mem_write_in, reg_write_in, reg_write0_in;
   logic [15:0] alu_out, rd1_out, r0_out;
   logic [3:0]  rr1_out, waddr_out;
   logic        mux_wb_out, mem_read_out, mem_write_out, reg_write_out, reg_write0_out;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   ex_mem_pipe_reg dut (
      .clock          (clock),
      .reset          (reset),
      .alu_in         (alu_in),
      .rd1_in         (rd1_in),
      .r0_in          (r0_in),
      .rr1_in         (rr1_in),
      .waddr_in       (waddr_in),
      .mux_wb_in      (mux_wb_in),
      .mem_read_in    (mem_read_in),
      .mem_write_in   (mem_write_in),
      .reg_write_in   (reg_write_in),
      .reg_write0_in  (reg_write0_in),
      .alu_out        (alu_out),
      .rd1_out        (rd1_out),
      .r0_out         (r0_out),
      .rr1_out        (rr1_out),
      .waddr_out      (waddr_out),
      .mux_wb_out     (mux_wb_out),
      .mem_read_out   (mem_read_out),
      .mem_write_out  (mem_write_out),
      .reg_write_out  (reg_write_out),
      .reg_write0_out (reg_write0_out)
   );

   task automatic drive(input fields_t f);
      alu_in        = f.alu;
      rd1_in        = f.rd1;
      r0_in         = f.r0;
      rr1_in        = f.rr1;
      waddr_in      = f.waddr;
      mux_wb_in     = f.ctrl[4];
      mem_read_in   = f.ctrl[3];
      mem_write_in  = f.ctrl[2];
      reg_write_in  = f.ctrl[1];
      reg_write0_in = f.ctrl[0];
   endtask

   task automatic check(input string name, input fields_t exp);
      fields_t got;
      got = '{alu: alu_out, rd1: rd1_out, r0: r0_out, rr1: rr1_out, waddr: waddr_out,
              ctrl: {mux_wb_out, mem_read_out, mem_write_out, reg_write_out, reg_write0_out}};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic fields_t randFields();
      fields_t f;
      f.alu   = 16'($urandom);
      f.rd1   = 16'($urandom);
      f.r0    = 16'($urandom);
      f.rr1   = 4'($urandom);
      f.waddr = 4'($urandom);
      f.ctrl  = 5'($urandom);
      return f;
   endfunction

   vec_t    tbl[8];
   fields_t a, b, model, cur;
   fields_t zero = '0;

   initial begin
      // Boundary / toggle patterns; each entry is captured one edge after being driven.
      tbl[0].stim = '{16'h8000, 16'h8000, 16'h8000, 4'hF, 4'hF, 5'b01100};
      tbl[0].exp  = '{16'h8000, 16'h8000, 16'h8000, 4'hF, 4'hF, 5'b01100};
      tbl[1].stim = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 4'h0, 4'h0, 5'b00011};
      tbl[1].exp  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 4'h0, 4'h0, 5'b00011};
      tbl[2].stim = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 5'b11111};
      tbl[2].exp  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 5'b11111};
      tbl[3].stim = '{16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 5'b00000};
      tbl[3].exp  = '{16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 5'b00000};
      tbl[4].stim = '{16'h5555, 16'hAAAA, 16'h5555, 4'h5, 4'hA, 5'b10101};
      tbl[4].exp  = '{16'h5555, 16'hAAAA, 16'h5555, 4'h5, 4'hA, 5'b10101};
      tbl[5].stim = '{16'hAAAA, 16'h5555, 16'hAAAA, 4'hA, 4'h5, 5'b01010};
      tbl[5].exp  = '{16'hAAAA, 16'h5555, 16'hAAAA, 4'hA, 4'h5, 5'b01010};
      tbl[6].stim = '{16'h0001, 16'h8001, 16'hFFFE, 4'h1, 4'h8, 5'b01000};
      tbl[6].exp  = '{16'h0001, 16'h8001, 16'hFFFE, 4'h1, 4'h8, 5'b01000};
      tbl[7].stim = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 5'b11111};
      tbl[7].exp  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 5'b11111};

      // Reset at time 0 with all-ones inputs.
      reset = 1'b1;
      drive('1);
      #1 check("reset_t0", zero);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1 check("reset_held", zero);
      end

      // Release between edges; first capture on the next edge.
      @(negedge clock);
      reset = 1'b0;
      a = '{16'h1234, 16'hABCD, 16'h0F0F, 4'h3, 4'h5, 5'b10011};
      drive(a);
      #1 check("pre_edge", zero);
      @(posedge clock); #1 check("first_capture", '{16'h1234, 16'hABCD, 16'h0F0F, 4'h3, 4'h5, 5'b10011});

      // Mid-cycle input change is invisible until the next edge.
      @(negedge clock);
      alu_in = 16'h0002;
      mem_write_in = 1'b1;
      #1 check("mid_cycle_hold", '{16'h1234, 16'hABCD, 16'h0F0F, 4'h3, 4'h5, 5'b10011});
      @(posedge clock); #1 check("mid_cycle_update", '{16'h0002, 16'hABCD, 16'h0F0F, 4'h3, 4'h5, 5'b10111});

      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         drive(tbl[i].stim);
         @(posedge clock); #1 check($sformatf("table_%0d", i), tbl[i].exp);
      end

      // Asynchronous reset between edges while outputs are all ones.
      @(negedge clock);
      reset = 1'b1;
      #1 check("async_clear", zero);
      reset = 1'b0;
      b = '{16'hC0DE, 16'h0BAD, 16'h1357, 4'h9, 4'h6, 5'b11001};
      drive(b);
      #1 check("after_release_no_capture", zero);
      @(posedge clock); #1 check("after_release_capture", '{16'hC0DE, 16'h0BAD, 16'h1357, 4'h9, 4'h6, 5'b11001});

      // Random stream: model holds the last value latched while reset was low.
      model = b;
      for (int i = 0; i < 300; i++) begin
         int sel;
         @(negedge clock);
         cur = randFields();
         drive(cur);
         sel = (i < 8) ? 0 : $urandom_range(0, 15);
         if (sel == 1) begin
            reset = 1'b1;
            model = '0;
            #1 check("rand_async_clear", model);
            reset = 1'b0;
         end else if (sel == 2) begin
            reset = 1'b1;
            model = '0;
            @(posedge clock); #1 check("rand_reset_held", model);
            @(negedge clock);
            reset = 1'b0;
            cur = randFields();
            drive(cur);
            #1 check("rand_release_no_capture", model);
         end else begin
            #1 check("rand_hold", model);
         end
         @(posedge clock);
         model = cur;
         #1 check("rand_capture", model);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- EX/MEM pipeline register of the 16-bit 5-stage CPU.
- Captures execute-stage results (ALU result, R0 side result, store data) with register addresses and the MEM/WB control bits on each rising clock edge.
- Presents them to the data memory, the forwarding unit and the MEM/WB register.
- Pure storage: no arithmetic, no stall, no flush.

Parameters:
- DATA_W, 16, width of the data/result fields.
- REG_ADDR_W, 4, width of the register-address fields (16 registers).

Ports:
- clock  in  1  single rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- alu_in  in  DATA_W  EX ALU result; memory address for load/store.
- rd1_in  in  DATA_W  RD1 operand from ID/EX; store data.
- r0_in  in  DATA_W  ALU secondary result destined for R0 (e.g. product high / remainder).
- rr1_in  in  REG_ADDR_W  source register 1 index; used by forwarding.
- waddr_in  in  REG_ADDR_W  destination register index.
- mux_wb_in  in  1  WB select: 0 = memory data, 1 = ALU result.
- mem_read_in  in  1  load enable.
- mem_write_in  in  1  store enable.
- reg_write_in  in  1  register-file write enable.
- reg_write0_in  in  1  R0 write enable.
- alu_out  out  DATA_W  registered alu_in.
- rd1_out  out  DATA_W  registered rd1_in.
- r0_out  out  DATA_W  registered r0_in.
- rr1_out  out  REG_ADDR_W  registered rr1_in.
- waddr_out  out  REG_ADDR_W  registered waddr_in.
- mux_wb_out, mem_read_out, mem_write_out, reg_write_out, reg_write0_out  out  1 each  registered controls.

Behaviour:
- Every output is a flip-flop. No combinational path from any input to any output.
- Reset asserted (reset=1):
  - All outputs go to 0 immediately, independent of clock.
  - All outputs stay 0 while reset is held. Clock edges are ignored.
- Reset deasserted: on each rising clock edge, every *_out takes the value its *_in had just before the edge.
  - Latency is exactly 1 cycle.
  - Outputs hold their values between edges.
- Reset state is a bubble (mem_read=mem_write=reg_write=reg_write0=0). Memory, register file and forwarding see no side effects.
- Reset mid-cycle: outputs clear at once. The first capture happens on the first rising edge after reset falls.
- Reset falling on a clock edge: that edge does not capture. The next edge does.
- All fields capture on the same edge. No partial update, no enable.
- Values pass through unchanged: no sign extension, no truncation, full-width copy.
- Illegal control combinations (e.g. mem_read and mem_write both 1) are stored as given. Checking them is upstream's job.

Decomposition:
- Shared cpu_pkg holds:
  - DATA_W=16 and REG_ADDR_W=4.
  - A packed struct ex_mem_ctrl_t {mux_wb, mem_read, mem_write, reg_write, reg_write0}, reused by the ID/EX and MEM/WB registers.
- One natural sub-module: pipe_reg. It is a width-parameterized flop with asynchronous active-high clear, instantiated per field or once on the concatenated bus.

Test Plan:
- Reset at time 0 with all inputs 16'hFFFF / 4'hF / 1 -> all outputs 0 before any clock edge; they stay 0 across 3 edges while reset=1.
- Release reset, drive alu_in=16'h1234, rd1_in=16'hABCD, r0_in=16'h0F0F, rr1_in=4'h3, waddr_in=4'h5, controls=5'b10011 -> unchanged before the edge; after the next rising edge, outputs equal those exact values.
- Change inputs mid-cycle to alu_in=16'h0002, mem_write_in=1 -> outputs unchanged until the next edge, then update to 16'h0002 and mem_write_out=1.
- Back-to-back stream of 8 random words over 8 consecutive edges -> each output is the previous cycle's input (1-cycle lag), every bit position toggled both ways.
- Assert reset between edges while outputs are nonzero -> all outputs 0 within the same timestep; deassert -> first capture on the following edge.
- Boundary values: alu_in=16'h8000 then 16'h7FFF, waddr_in=4'hF then 4'h0 -> captured bit-exact (no sign handling).
